// File: rtl/mul_seq_ctrl.sv
// 2N x 2N multiply sequenced over four cycles through one N x N Wallace-tree
// multiplier, with per-operand signedness and valid/ready handshakes.

module mul #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_x,
  input  logic [N-1:0]   i_y,
  input  logic [1:0]     i_s,   // [1]=x signed, [0]=y signed
  output logic [2*N-1:0] o_p
);
  localparam int W  = 2 * N;
  localparam int IW = $clog2(W);

  logic [W-1:0] w_xe, w_ye;

  // Extending both operands to 2N bits lets one modulo-2^2N array cover every
  // signedness mix; the exact product always fits 2N bits.
  assign w_xe = {{N{i_s[1] & i_x[N-1]}}, i_x};
  assign w_ye = {{N{i_s[0] & i_y[N-1]}}, i_y};

  always_comb begin : p_tree
    logic [W-1:0] rows [W];
    logic [W-1:0] nxt  [W];
    int cnt;
    int nc;
    for (int r = 0; r < W; r++)
      rows[r] = w_ye[IW'(r)] ? (w_xe << r) : '0;
    cnt = W;
    // 3:2 carry-save levels until two rows remain
    for (int l = 0; l < W; l++) begin
      for (int r = 0; r < W; r++) nxt[r] = '0;
      nc = 0;
      for (int g = 0; g < W; g += 3) begin
        if (g + 2 < cnt) begin
          nxt[IW'(nc)]     = rows[IW'(g)] ^ rows[IW'(g+1)] ^ rows[IW'(g+2)];
          nxt[IW'(nc + 1)] = ((rows[IW'(g)] & rows[IW'(g+1)]) |
                              (rows[IW'(g)] & rows[IW'(g+2)]) |
                              (rows[IW'(g+1)] & rows[IW'(g+2)])) << 1;
          nc += 2;
        end else if (g < cnt) begin
          nxt[IW'(nc)] = rows[IW'(g)];
          nc += 1;
          if (g + 1 < cnt) begin
            nxt[IW'(nc)] = rows[IW'(g+1)];
            nc += 1;
          end
        end
      end
      if (cnt > 2) begin
        for (int r = 0; r < W; r++) rows[r] = nxt[r];
        cnt = nc;
      end
    end
    o_p = rows[0] + rows[1];
  end
endmodule

module mul_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [1:0]     signed_i,
  input  logic [2*N-1:0] a_i,
  input  logic [2*N-1:0] b_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [4*N-1:0] prod_o,
  output logic           busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t         r_state;
  logic [1:0]     r_step;
  logic [4*N-1:0] r_acc;
  logic [2*N-1:0] r_a, r_b;
  logic           r_sa, r_sb;
  logic           r_in_ready, r_out_valid, r_busy;

  logic [N-1:0]   w_x, w_y;
  logic [1:0]     w_s;
  logic [2*N-1:0] w_pp;
  logic [4*N-1:0] w_pp_ext, w_term;

  // step[1] picks the high half of a, step[0] the high half of b
  assign w_x = r_step[1] ? r_a[2*N-1:N] : r_a[N-1:0];
  assign w_y = r_step[0] ? r_b[2*N-1:N] : r_b[N-1:0];
  assign w_s = {r_step[1] & r_sa, r_step[0] & r_sb};

  mul #(.N(N)) u_mul (
    .i_x (w_x),
    .i_y (w_y),
    .i_s (w_s),
    .o_p (w_pp)
  );

  assign w_pp_ext = (w_s != 2'b00) ? {{(2*N){w_pp[2*N-1]}}, w_pp}
                                   : {{(2*N){1'b0}}, w_pp};

  always_comb begin
    w_term = w_pp_ext;
    unique case (r_step)
      2'd0:       w_term = w_pp_ext;
      2'd1, 2'd2: w_term = w_pp_ext << N;
      2'd3:       w_term = w_pp_ext << (2 * N);
      default:    w_term = w_pp_ext;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clear_i) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_acc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid_i && r_in_ready) begin
          r_a        <= a_i;
          r_b        <= b_i;
          r_sa       <= signed_i[1];
          r_sb       <= signed_i[0];
          r_acc      <= '0;
          r_step     <= '0;
          r_state    <= S_MUL;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        S_MUL: begin
          r_acc  <= r_acc + w_term;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (out_ready_i) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign prod_o      = r_acc;
endmodule
